load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Load/store unit between a pipeline request port and a
//               word-indexed data memory with combinational read and
//               clocked write. Byte and halfword stores are done as a
//               read-modify-write (ACCESS reads the word, WRITE stores the
//               merged word). Misaligned ops and the reserved size are
//               rejected with no memory access.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               req_valid / req_ready - op handshake (ready only when idle)
//               req_write, req_size, req_unsigned, req_Address,
//               req_WriteData         - op description, sampled on accept
//               resp_valid            - one-cycle completion pulse
//               resp_ReadData         - extended load data (0 for stores and
//                                       rejected ops)
//               resp_misaligned       - op was rejected
//               mem_Address           - word index into the data memory
//               mem_WriteData, mem_MemWrite, mem_MemRead, mem_ReadData
//                                     - data memory port
//
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_Address,
    input  logic [DATA_WIDTH-1:0] req_WriteData,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_ReadData,
    output logic                  resp_misaligned,
    output logic [31:0]           mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    input  logic [DATA_WIDTH-1:0] mem_ReadData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0]  c_SIZE_BYTE = 2'b00;
    localparam logic [1:0]  c_SIZE_HALF = 2'b01;
    localparam logic [1:0]  c_SIZE_WORD = 2'b10;
    localparam logic [31:0] c_WORD_MASK = 32'(MEMORY_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_nextState;

    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [31:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_merged;
    logic [DATA_WIDTH-1:0]   r_readData;
    logic                    r_misaligned;

    logic                    w_accept;
    logic                    w_reqMisaligned;
    logic [31:0]             w_wordIndex;
    logic [4:0]              w_laneShift;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_loadData;
    logic [DATA_WIDTH-1:0]   w_laneMask;
    logic [DATA_WIDTH-1:0]   w_mergedData;
    logic                    w_subWord;
    logic                    w_memWriteReq;

    assign req_ready       = (r_state == S_IDLE);
    assign resp_valid      = (r_state == S_RESP);
    assign resp_ReadData   = r_readData;
    assign resp_misaligned = r_misaligned;

    assign w_accept = req_valid && req_ready;

    // Reserved size is rejected regardless of address.
    assign w_reqMisaligned = ((req_size == c_SIZE_HALF) && req_Address[0])
                          || ((req_size == c_SIZE_WORD) && (req_Address[1:0] != 2'b00))
                          || (req_size == 2'b11);

    assign w_wordIndex = (r_addr >> 2) & c_WORD_MASK;
    assign w_subWord   = (r_size != c_SIZE_WORD);

    // Aligned halfwords have addr[0]=0, so the byte-lane shift also selects
    // the correct halfword lane.
    assign w_laneShift = {r_addr[1:0], 3'b000};
    assign w_shifted   = mem_ReadData >> w_laneShift;

    always_comb begin
        w_loadData = mem_ReadData;
        w_laneMask = '0;
        case (r_size)
            c_SIZE_BYTE: begin
                w_loadData = r_unsigned ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
                w_laneMask = 32'h0000_00FF << w_laneShift;
            end
            c_SIZE_HALF: begin
                w_loadData = r_unsigned ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
                w_laneMask = 32'h0000_FFFF << w_laneShift;
            end
            default: begin
                w_loadData = mem_ReadData;
                w_laneMask = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Store data is right-justified; move it to its lane and overlay it on
    // the current memory word.
    assign w_mergedData = (mem_ReadData & ~w_laneMask)
                        | ((r_wdata << w_laneShift) & w_laneMask);

    always_comb begin
        w_nextState   = r_state;
        mem_Address   = '0;
        mem_WriteData = '0;
        mem_MemRead   = 1'b0;
        w_memWriteReq = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_reqMisaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_Address = w_wordIndex;
                mem_MemRead = 1'b1;
                if (r_write && w_subWord) begin
                    w_nextState = S_WRITE;
                end else begin
                    if (r_write) begin
                        w_memWriteReq = 1'b1;
                        mem_WriteData = r_wdata;
                    end
                    w_nextState = S_RESP;
                end
            end
            S_WRITE: begin
                mem_Address   = w_wordIndex;
                mem_WriteData = r_merged;
                w_memWriteReq = 1'b1;
                w_nextState   = S_RESP;
            end
            S_RESP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // The write strobe is suppressed combinationally while reset is high so
    // an op aborted by reset never reaches memory on that edge.
    assign mem_MemWrite = w_memWriteReq && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_readData   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_write      <= req_write;
                r_size       <= req_size;
                r_unsigned   <= req_unsigned;
                r_addr       <= req_Address;
                r_wdata      <= req_WriteData;
                r_readData   <= '0;
                r_misaligned <= w_reqMisaligned;
            end
            if ((r_state == S_ACCESS) && !r_write) begin
                r_readData <= w_loadData;
            end
            if ((r_state == S_ACCESS) && r_write && w_subWord) begin
                r_merged <= w_mergedData;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A behavioural
//               byte-addressed memory model predicts load data, latency,
//               memory strobes and memory contents for directed and random
//               ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_Address;
    logic [31:0] req_WriteData;
    logic        resp_valid;
    logic [31:0] resp_ReadData;
    logic        resp_misaligned;
    logic [31:0] mem_Address;
    logic [31:0] mem_WriteData;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_ReadData;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    load_store_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_Address    (req_Address),
        .req_WriteData  (req_WriteData),
        .resp_valid     (resp_valid),
        .resp_ReadData  (resp_ReadData),
        .resp_misaligned(resp_misaligned),
        .mem_Address    (mem_Address),
        .mem_WriteData  (mem_WriteData),
        .mem_MemWrite   (mem_MemWrite),
        .mem_MemRead    (mem_MemRead),
        .mem_ReadData   (mem_ReadData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Memory driven by the DUT: combinational read, clocked write.
    logic [31:0] mem [DEPTH];
    assign mem_ReadData = mem[mem_Address[9:0]];
    always @(posedge clk) if (mem_MemWrite) mem[mem_Address[9:0]] <= mem_WriteData;

    // Reference model memory, byte addressed.
    logic [7:0] refB [4*DEPTH];

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input int idx);
        return {refB[4*idx+3], refB[4*idx+2], refB[4*idx+1], refB[4*idx]};
    endfunction

    task automatic setWord(input int idx, input logic [31:0] v);
        mem[idx] = v;
        for (int k = 0; k < 4; k++) refB[4*idx+k] = v[8*k +: 8];
    endtask

    function automatic logic refMis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic un, input int a);
        logic [15:0] h;
        case (sz)
            2'd0: return un ? {24'h0, refB[a]} : {{24{refB[a][7]}}, refB[a]};
            2'd1: begin
                h = {refB[a+1], refB[a]};
                return un ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return {refB[a+3], refB[a+2], refB[a+1], refB[a]};
        endcase
    endfunction

    // Performs one op. lat counts sample points from the accept edge to the
    // first resp_valid (1 = the cycle right after accept). writeAt records the
    // sample point at which mem_MemWrite was seen (0 = never).
    task automatic doOp(input logic w, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic mis,
                        output int nRd, output int nWr, output int writeAt,
                        output int accEdge, output int respEdge);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (!req_ready) checkValue("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = un;
        req_Address = a; req_WriteData = d;
        @(posedge clk); #1;
        accEdge = cycle;
        // Inputs outside acceptance must be ignored.
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_Address = $urandom; req_WriteData = $urandom;
        lat = 1; nRd = 0; nWr = 0; writeAt = 0;
        while (!resp_valid && lat < 10) begin
            nRd += int'(mem_MemRead);
            if (mem_MemWrite) begin nWr++; writeAt = lat; end
            @(posedge clk); #1; lat++;
        end
        nRd += int'(mem_MemRead);
        nWr += int'(mem_MemWrite);
        if (!resp_valid) lat = 99;
        rd = resp_ReadData; mis = resp_misaligned; respEdge = cycle;
    endtask

    // Runs an op, compares it against the model and updates the model.
    task automatic runChecked(input string tag, input logic w, input logic [1:0] sz,
                              input logic un, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output int lat,
                              output int accEdge, output int respEdge);
        int nRd, nWr, writeAt, expLat, widx;
        logic mis, expMis;
        logic [31:0] expRd;
        expMis = refMis(sz, a);
        widx   = int'(a[9:2]);
        expRd  = (expMis || w) ? 32'h0 : refLoad(sz, un, int'(a[11:0]));
        expLat = expMis ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        doOp(w, sz, un, a, d, lat, rd, mis, nRd, nWr, writeAt, accEdge, respEdge);
        if (w && !expMis) begin
            if (sz == 2'd0) refB[a] = d[7:0];
            else if (sz == 2'd1) begin refB[a] = d[7:0]; refB[a+1] = d[15:8]; end
            else for (int k = 0; k < 4; k++) refB[a+k] = d[8*k +: 8];
        end
        checkValue({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkValue({tag, "_rdata"}, rd, expRd);
        checkValue({tag, "_mis"}, 32'(mis), 32'(expMis));
        checkValue({tag, "_reads"}, 32'(nRd), expMis ? 32'd0 : 32'd1);
        checkValue({tag, "_writes"}, 32'(nWr), (w && !expMis) ? 32'd1 : 32'd0);
        if (w && !expMis)
            checkValue({tag, "_write_slot"}, 32'(writeAt), (sz == 2'd2) ? 32'd1 : 32'd2);
        checkValue({tag, "_memword"}, mem[widx], refWord(widx));
    endtask

    initial begin
        logic [31:0] rd;
        int lat, accA, respA, accB, respB, seenResp;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_Address = '0; req_WriteData = '0;
        for (int i = 0; i < DEPTH; i++) setWord(i, $urandom);
        setWord(5, 32'h8899AABB);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkValue("rst_ready", 32'(req_ready), 32'd1);
        checkValue("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkValue("rst_rdata", resp_ReadData, 32'd0);
        checkValue("rst_mis", 32'(resp_misaligned), 32'd0);
        checkValue("rst_memwrite", 32'(mem_MemWrite), 32'd0);
        checkValue("rst_memread", 32'(mem_MemRead), 32'd0);
        checkValue("rst_memaddr", mem_Address, 32'd0);
        checkValue("rst_memwdata", mem_WriteData, 32'd0);

        // Directed ops on word 5 = 0x8899AABB.
        runChecked("lb16", 1'b0, 2'd0, 1'b0, 32'h16, 32'h0, rd, lat, accA, respA);
        checkValue("lb16_const", rd, 32'hFFFFFF99);
        checkValue("lb16_lat_const", 32'(lat), 32'd2);
        runChecked("lhu16", 1'b0, 2'd1, 1'b1, 32'h16, 32'h0, rd, lat, accA, respA);
        checkValue("lhu16_const", rd, 32'h00008899);
        runChecked("lw14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, lat, accA, respA);
        checkValue("lw14_const", rd, 32'h8899AABB);
        runChecked("sb15", 1'b1, 2'd0, 1'b0, 32'h15, 32'h000000CC, rd, lat, accA, respA);
        checkValue("sb15_word_const", mem[5], 32'h8899CCBB);
        checkValue("sb15_lat_const", 32'(lat), 32'd3);
        runChecked("lw16_mis", 1'b0, 2'd2, 1'b0, 32'h16, 32'h0, rd, lat, accA, respA);
        checkValue("lw16_mis_lat_const", 32'(lat), 32'd1);
        checkValue("lw16_mis_rdata_const", rd, 32'h0);
        @(posedge clk); #1;

        // Reset during WRITE of sh 0xBEEF at 0x14 aborts the op.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_Address = 32'h14; req_WriteData = 32'h0000BEEF;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        checkValue("abort_in_write", 32'(mem_MemWrite), 32'd1);
        reset = 1'b1; #1;
        checkValue("abort_write_gated", 32'(mem_MemWrite), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        checkValue("abort_ready", 32'(req_ready), 32'd1);
        checkValue("abort_word5", mem[5], 32'h8899CCBB);
        seenResp = 0;
        for (int i = 0; i < 4; i++) begin
            seenResp += int'(resp_valid);
            @(posedge clk); #1;
        end
        checkValue("abort_no_resp", 32'(seenResp), 32'd0);

        // Back-to-back store then load.
        runChecked("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, rd, lat, accA, respA);
        runChecked("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, lat, accB, respB);
        checkValue("b2b_accept_gap", 32'(accB - respA), 32'd2);
        checkValue("b2b_rdata_const", rd, 32'h12345678);
        @(posedge clk); #1;
        checkValue("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);

        // Random ops over the first 16 words.
        for (int n = 0; n < 60; n++) begin
            runChecked("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                       32'($urandom_range(0, 63)), $urandom, rd, lat, accA, respA);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                checkValue("rand_pulse", 32'(resp_valid), 32'd0);
            end
        end

        for (int i = 0; i < 16; i++) checkValue("final_mem", mem[i], refWord(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
